// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: shared types and constants for the APB command master.
// Holds the FSM encoding, the APB data width and the bus reset defaults.
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int APB_DW = 32;

    localparam logic [APB_DW-1:0] PWDATA_RST = '0;
    localparam logic [APB_DW-1:0] RDATA_RST  = '0;
    localparam logic              PWRITE_RST = 1'b0;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: wait-state counter with clear, saturating increment
// and a match flag at TIMEOUT-1. TIMEOUT=0 keeps the match flag low.
module apb_wait_timer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_match
);

    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat   = (r_cnt == {CNT_W{1'b1}});
    assign o_match = (TIMEOUT != 0) && (r_cnt == LIMIT);

    // Count stalled cycles; clear has priority, saturate at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command to single APB3 transfer bridge.
// One transfer in flight; stalled completers are aborted by a timer.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    state_t r_state;
    logic   w_clr;
    logic   w_inc;
    logic   w_match;
    logic   w_unused_addr;

    // Word-aligned bus: the byte-lane bits of the command are dropped.
    assign w_unused_addr = ^cmd_addr[1:0];

    assign cmd_ready = (r_state == IDLE);
    assign w_clr     = (r_state == SETUP);
    assign w_inc     = (r_state == ACCESS) && !PREADY && !w_match;

    apb_wait_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk   (PCLK),
        .i_rst_n (PRESETn),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .o_match (w_match)
    );

    // Transfer sequencer; every bus and response output is registered here.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= PWRITE_RST;
            PADDR       <= '0;
            PWDATA      <= PWDATA_RST;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= RDATA_RST;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= {cmd_addr[ADDR_W-1:2], 2'b00};
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_rdata   <= PWRITE ? RDATA_RST : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_match) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_rdata   <= RDATA_RST;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scenario tasks plus randomized transfers checked
// against a transaction-level model of latency, data and status.
module tb_apb_cmd_master;

    localparam int AW = 12;
    localparam int TO = 4;
    localparam int CW = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic [AW-1:0] PADDR;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    apb_cmd_master #(
        .ADDR_W  (AW),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PADDR       (PADDR),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int            lat;
        int            psel_n;
        int            pen_n;
        logic [31:0]   rdata;
        logic          err;
        logic          to;
        logic [AW-1:0] paddr;
    } exp_t;

    typedef struct {
        int            lat;
        int            psel_n;
        int            pen_n;
        int            bad;
        logic [31:0]   rdata;
        logic          err;
        logic          to;
        logic [AW-1:0] paddr;
        logic [31:0]   pwdata;
        logic          pwrite;
    } obs_t;

    // Transaction model: waits = ACCESS cycles the completer stalls.
    function automatic exp_t model(input logic wr, input logic [AW-1:0] a,
                                   input int waits, input logic [31:0] prd,
                                   input logic serr);
        exp_t m;
        bit   tmo;
        int   acc;
        tmo      = (TO != 0) && (waits >= TO);
        acc      = tmo ? TO : waits + 1;
        m.lat    = 2 + acc;
        m.psel_n = 1 + acc;
        m.pen_n  = acc;
        m.rdata  = (tmo || wr) ? 32'h0 : prd;
        m.err    = tmo ? 1'b1 : serr;
        m.to     = tmo;
        m.paddr  = a & ~AW'(3);
        return m;
    endfunction

    // Drives one command, plays the completer, records what the bus did.
    task automatic run_xfer(input logic wr, input logic [AW-1:0] a,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] prd, input logic serr,
                            input bit release_rsp, output obs_t o);
        int acc;
        int c;
        acc = 0;
        o.lat = -1; o.psel_n = 0; o.pen_n = 0; o.bad = 0;
        o.rdata = '0; o.err = 0; o.to = 0;
        o.paddr = '0; o.pwdata = '0; o.pwrite = 0;
        cmd_valid = 1'b1; cmd_write = wr;
        cmd_addr = a; cmd_wdata = wd;
        rsp_ready = release_rsp;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_write = ~wr;
        cmd_addr = AW'($urandom); cmd_wdata = $urandom;
        for (c = 1; c < 200; c++) begin
            if (PSEL && PENABLE) acc++;
            PREADY  = PSEL && PENABLE && (acc > waits);
            PRDATA  = PREADY ? prd : $urandom;
            PSLVERR = PREADY ? serr : 1'($urandom_range(0, 1));
            @(negedge PCLK);
            if (PSEL) begin
                o.psel_n++;
                if (o.psel_n == 1) begin
                    o.paddr = PADDR; o.pwdata = PWDATA; o.pwrite = PWRITE;
                end else if (PADDR !== o.paddr || PWDATA !== o.pwdata ||
                             PWRITE !== o.pwrite) begin
                    o.bad++;
                end
            end
            if (PENABLE) begin
                o.pen_n++;
                if (!PSEL) o.bad++;
            end
            if (rsp_valid) begin
                o.lat = c; o.rdata = rsp_rdata;
                o.err = rsp_err; o.to = rsp_timeout;
                break;
            end
            @(posedge PCLK); #1;
        end
        PREADY = 1'b0;
        if (o.lat < 0) begin
            PRESETn = 1'b0; #2; PRESETn = 1'b1;
        end else if (release_rsp) begin
            @(posedge PCLK); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid,
             rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h pwdata=%h rv=%b rd=%h", PSEL, PENABLE, PADDR, PWDATA, rsp_valid, rsp_rdata);
        end else n_pass++;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(negedge PCLK);
        n_chk++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
            $display("FAIL reset_idle: got cmd_ready=%b psel=%b want 1 0", cmd_ready, PSEL);
        end else n_pass++;
    endtask

    task automatic test_write_basic();
        obs_t o;
        exp_t e;
        e = model(1'b1, 12'h000, 0, 32'h0, 1'b0);
        run_xfer(1'b1, 12'h000, 32'h3, 0, 32'h5555_AAAA, 1'b0, 1'b1, o);
        n_chk++;
        if (o.lat !== e.lat || o.psel_n !== e.psel_n || o.pen_n !== e.pen_n) begin
            $display("FAIL write_timing: got lat=%0d psel=%0d pen=%0d want %0d %0d %0d", o.lat, o.psel_n, o.pen_n, e.lat, e.psel_n, e.pen_n);
        end else n_pass++;
        n_chk++;
        if (o.paddr !== 12'h000 || o.pwdata !== 32'h3 || o.pwrite !== 1'b1) begin
            $display("FAIL write_bus: got paddr=%h pwdata=%h pwrite=%b want 000 3 1", o.paddr, o.pwdata, o.pwrite);
        end else n_pass++;
        n_chk++;
        if (o.rdata !== 32'h0 || o.err !== 1'b0 || o.to !== 1'b0) begin
            $display("FAIL write_rsp: got rd=%h err=%b to=%b want 0 0 0", o.rdata, o.err, o.to);
        end else n_pass++;
        @(negedge PCLK);
        n_chk++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL write_return_idle: got cmd_ready=%b rv=%b want 1 0", cmd_ready, rsp_valid);
        end else n_pass++;
        @(posedge PCLK); #1;
    endtask

    task automatic test_read_wait();
        obs_t o;
        exp_t e;
        e = model(1'b0, 12'h018, 3, 32'hDEAD_BEEF, 1'b0);
        run_xfer(1'b0, 12'h018, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b1, o);
        n_chk++;
        if (o.lat !== 6 || o.lat !== e.lat) begin
            $display("FAIL read_wait_lat: got %0d want %0d", o.lat, e.lat);
        end else n_pass++;
        n_chk++;
        if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin
            $display("FAIL read_wait_data: got %h err=%b want deadbeef 0", o.rdata, o.err);
        end else n_pass++;
        n_chk++;
        if (o.bad !== 0 || o.paddr !== 12'h018) begin
            $display("FAIL read_wait_stable: got bad=%0d paddr=%h want 0 018", o.bad, o.paddr);
        end else n_pass++;
    endtask

    task automatic test_slverr();
        obs_t o;
        run_xfer(1'b0, 12'h04C, 32'h0, 0, 32'h1234_5678, 1'b1, 1'b1, o);
        n_chk++;
        if (o.err !== 1'b1 || o.to !== 1'b0 || o.lat !== 3) begin
            $display("FAIL slverr: got err=%b to=%b lat=%0d want 1 0 3", o.err, o.to, o.lat);
        end else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        e = model(1'b0, 12'h0A0, 1000, 32'h0, 1'b0);
        run_xfer(1'b0, 12'h0A0, 32'h0, 1000, 32'hFFFF_0000, 1'b0, 1'b1, o);
        n_chk++;
        if (o.pen_n !== TO || o.psel_n !== e.psel_n || o.lat !== e.lat) begin
            $display("FAIL timeout_cycles: got access=%0d psel=%0d lat=%0d want %0d %0d %0d", o.pen_n, o.psel_n, o.lat, TO, e.psel_n, e.lat);
        end else n_pass++;
        n_chk++;
        if (o.err !== 1'b1 || o.to !== 1'b1 || o.rdata !== 32'h0) begin
            $display("FAIL timeout_rsp: got err=%b to=%b rd=%h want 1 1 0", o.err, o.to, o.rdata);
        end else n_pass++;
        e = model(1'b0, 12'h0A4, TO - 1, 32'hCAFE_F00D, 1'b0);
        run_xfer(1'b0, 12'h0A4, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0, 1'b1, o);
        n_chk++;
        if (o.to !== 1'b0 || o.err !== 1'b0 || o.rdata !== e.rdata || o.lat !== e.lat) begin
            $display("FAIL timeout_race: got to=%b err=%b rd=%h lat=%0d want 0 0 %h %0d", o.to, o.err, o.rdata, o.lat, e.rdata, e.lat);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   bad;
        bad = 0;
        run_xfer(1'b0, 12'h020, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 1'b0, o);
        for (int h = 0; h < 5; h++) begin
            @(posedge PCLK); #1;
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h1A4;
            @(negedge PCLK);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D ||
                rsp_err !== 1'b1 || rsp_timeout !== 1'b0 ||
                cmd_ready !== 1'b0 || PSEL !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end else n_pass++;
        @(posedge PCLK); #1;
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        @(negedge PCLK);
        n_chk++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0 || rsp_valid !== 1'b0) begin
            $display("FAIL bp_release: got cmd_ready=%b psel=%b rv=%b want 1 0 0", cmd_ready, PSEL, rsp_valid);
        end else n_pass++;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(negedge PCLK);
        n_chk++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 12'h1A4) begin
            $display("FAIL bp_next_accept: got psel=%b pen=%b paddr=%h want 1 0 1a4", PSEL, PENABLE, PADDR);
        end else n_pass++;
        @(posedge PCLK); #1;
        PREADY = 1'b1; rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        PREADY = 1'b0;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h08C;
        rsp_ready = 1'b1; PREADY = 1'b0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        n_chk++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || PADDR !== '0) begin
            $display("FAIL reset_mid_async: got psel=%b pen=%b rv=%b paddr=%h want 0 0 0 0", PSEL, PENABLE, rsp_valid, PADDR);
        end else n_pass++;
        @(posedge PCLK); #1;
        PRESETn = 1'b1; rsp_ready = 1'b0;
        @(negedge PCLK);
        n_chk++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
            $display("FAIL reset_mid_idle: got cmd_ready=%b psel=%b want 1 0", cmd_ready, PSEL);
        end else n_pass++;
        run_xfer(1'b0, 12'h3FF, 32'h0, 0, 32'h7777_1111, 1'b0, 1'b1, o);
        n_chk++;
        if (o.paddr !== 12'h3FC || o.lat !== 3 || o.rdata !== 32'h7777_1111) begin
            $display("FAIL reset_mid_next: got paddr=%h lat=%0d rd=%h want 3fc 3 77771111", o.paddr, o.lat, o.rdata);
        end else n_pass++;
    endtask

    task automatic test_random();
        obs_t          o;
        exp_t          e;
        logic          wr;
        logic          serr;
        logic [AW-1:0] a;
        logic [31:0]   wd;
        logic [31:0]   prd;
        int            w;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom_range(0, 1));
            serr = 1'($urandom_range(0, 1));
            a    = AW'($urandom);
            wd   = $urandom;
            prd  = $urandom;
            w    = $urandom_range(0, TO + 2);
            e    = model(wr, a, w, prd, serr);
            run_xfer(wr, a, wd, w, prd, serr, 1'b1, o);
            n_chk++;
            if (o.lat !== e.lat || o.psel_n !== e.psel_n || o.pen_n !== e.pen_n) begin
                $display("FAIL rnd_timing[%0d]: got lat=%0d psel=%0d pen=%0d want %0d %0d %0d", i, o.lat, o.psel_n, o.pen_n, e.lat, e.psel_n, e.pen_n);
            end else n_pass++;
            n_chk++;
            if (o.rdata !== e.rdata || o.err !== e.err || o.to !== e.to) begin
                $display("FAIL rnd_rsp[%0d]: got rd=%h err=%b to=%b want %h %b %b", i, o.rdata, o.err, o.to, e.rdata, e.err, e.to);
            end else n_pass++;
            n_chk++;
            if (o.paddr !== e.paddr || o.pwdata !== wd || o.pwrite !== wr || o.bad !== 0) begin
                $display("FAIL rnd_bus[%0d]: got paddr=%h pwdata=%h pwrite=%b bad=%0d want %h %h %b 0", i, o.paddr, o.pwdata, o.pwrite, o.bad, e.paddr, wd, wr);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
